// File: rtl/sign_capture_controller.sv
// Debounces the raw finger pattern, applies stable patterns to SignIdentification,
// captures the resulting sign once per gesture and queues it in a small valid/ready FIFO.
module sign_capture_controller #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] finger_in,
  output logic [4:0] finger_out,
  input  logic [3:0] sign_value,
  output logic [3:0] sign_out,
  output logic       sign_valid,
  input  logic       sign_ready,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  LAST_CNT = 8'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, APPLY, CAPTURE, HOLD} state_t;

  state_t      state, state_nx;
  logic [4:0]  cand, cand_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [4:0]  finger_nx;
  logic        push;

  logic [3:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic        pop, full, do_push, drop;

  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    cnt_nx    = cnt;
    finger_nx = finger_out;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          cand_nx  = finger_in;
          cnt_nx   = 8'd0;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (finger_in != cand) begin
          cand_nx = finger_in;
          cnt_nx  = 8'd0;
        end else if (cnt == LAST_CNT) begin
          finger_nx = cand;
          state_nx  = APPLY;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      APPLY:   state_nx = CAPTURE;
      CAPTURE: begin
        push     = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (finger_in != finger_out) begin
          cand_nx  = finger_in;
          cnt_nx   = 8'd0;
          state_nx = SETTLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Stopping freezes the datapath registers; only the pending capture push survives.
    if (!enable) begin
      state_nx  = IDLE;
      cand_nx   = cand;
      cnt_nx    = cnt;
      finger_nx = finger_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= 5'd0;
      cnt        <= 8'd0;
      finger_out <= 5'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cand       <= cand_nx;
      cnt        <= cnt_nx;
      finger_out <= finger_nx;
      busy       <= (state_nx == SETTLE) || (state_nx == APPLY) || (state_nx == CAPTURE);
    end
  end

  // FIFO: a pop frees the slot a simultaneous push needs, so full+pop+push is legal.
  assign sign_valid = (occ != '0);
  assign full       = (occ == FULL_OCC);
  assign pop        = sign_valid & sign_ready;
  assign do_push    = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign sign_out   = sign_valid ? mem[rd_ptr] : 4'd0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= sign_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sign_capture_controller.sv
// Bench for sign_capture_controller: per-edge input sequences are run against a
// sequence-level model of debounce/capture timing plus a queue-based FIFO model.
module tb_sign_capture_controller;

  localparam int S = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, enable, sign_ready, sign_valid, overflow, busy;
  logic [4:0] finger_in, finger_out;
  logic [3:0] sign_value, sign_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] xs[$];
  bit         rdy[$];

  always #5 clk = ~clk;

  sign_capture_controller #(.STABLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .finger_in(finger_in),
    .finger_out(finger_out), .sign_value(sign_value), .sign_out(sign_out),
    .sign_valid(sign_valid), .sign_ready(sign_ready), .overflow(overflow),
    .busy(busy)
  );

  function automatic logic [3:0] sign_code(logic [4:0] p);
    return 4'((int'(p) * 7 + 3) % 16);
  endfunction

  // Stand-in for SignIdentification: registers the code of the applied pattern.
  always_ff @(posedge clk) sign_value <= sign_code(finger_out);

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; sign_ready = 1'b0; finger_in = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    chk({name, ".rst_valid"}, sign_valid, 0);
    chk({name, ".rst_fo"}, finger_out, 0);
    chk({name, ".rst_out"}, sign_out, 0);
    chk({name, ".rst_ovf"}, overflow, 0);
    chk({name, ".rst_busy"}, busy, 0);
  endtask

  task automatic add(logic [4:0] p, int len, bit r);
    repeat (len) begin
      xs.push_back(p);
      rdy.push_back(r);
    end
  endtask

  // Applies xs/rdy one sample per edge (edge 0 = first sample after reset).
  task automatic run_seq(string name);
    int n;
    int push_code[];
    int fo_set[];
    bit busy_e[];
    int q[$];
    bit ovf;
    int fo;
    int s;
    int t;
    n = xs.size();
    push_code = new[n];
    fo_set    = new[n];
    busy_e    = new[n];
    for (int k = 0; k < n; k++) begin
      push_code[k] = -1; fo_set[k] = -1; busy_e[k] = 0;
    end
    // A pattern loaded at edge s is applied at s+S if the next S samples match it,
    // captured at s+S+2, and then held until the input departs from it.
    s = 0;
    while (s < n) begin
      t = s + 1;
      while (t <= s + S && t < n && xs[t] == xs[s]) t++;
      if (t <= s + S) begin
        for (int k = s; k < t; k++) busy_e[k] = 1;
        s = t;
      end else begin
        for (int k = s; k <= s + S + 1 && k < n; k++) busy_e[k] = 1;
        fo_set[s+S] = xs[s];
        if (s + S + 2 < n) push_code[s+S+2] = sign_code(xs[s]);
        t = s + S + 3;
        while (t < n && xs[t] == xs[s]) t++;
        s = t;
      end
    end

    do_reset(name);
    enable = 1'b1;
    ovf = 0;
    fo  = 0;
    for (int e = 0; e < n; e++) begin
      bit full;
      bit pop;
      finger_in  = xs[e];
      sign_ready = rdy[e];
      @(posedge clk);
      full = (q.size() == D);
      pop  = (q.size() > 0) && rdy[e];
      if (pop) void'(q.pop_front());
      if (push_code[e] >= 0) begin
        if (!full || pop) q.push_back(push_code[e]);
        else ovf = 1;
      end
      if (fo_set[e] >= 0) fo = fo_set[e];
      #1;
      chk($sformatf("%s.valid@%0d", name, e), sign_valid, q.size() > 0);
      chk($sformatf("%s.out@%0d", name, e), sign_out, (q.size() > 0) ? q[0] : 0);
      chk($sformatf("%s.ovf@%0d", name, e), overflow, ovf);
      chk($sformatf("%s.fo@%0d", name, e), finger_out, fo);
      chk($sformatf("%s.busy@%0d", name, e), busy, busy_e[e]);
      @(negedge clk);
    end
    xs.delete();
    rdy.delete();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; sign_ready = 1'b0; finger_in = 5'd0;

    add(5'b00010, 12, 0);
    run_seq("basic");

    add(5'b00110, 3, 0); add(5'b00111, 1, 0); add(5'b00110, 14, 0);
    run_seq("glitch");

    add(5'b11111, 50, 0); add(5'b00010, 10, 0);
    run_seq("hold");

    add(5'b00001, 9, 0); add(5'b00011, 9, 0); add(5'b00111, 9, 0);
    add(5'b01111, 9, 0); add(5'b11111, 9, 0); add(5'b11111, 10, 1);
    run_seq("ovf");

    add(5'b00001, 9, 0); add(5'b00011, 9, 0); add(5'b00111, 9, 0);
    add(5'b01111, 9, 0); add(5'b11111, 12, 0);
    rdy[42] = 1;
    run_seq("fullpop");

    // Asynchronous reset with entries queued, taken between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_q.valid", sign_valid, 0);
    chk("arst_q.fo", finger_out, 0);
    chk("arst_q.busy", busy, 0);
    chk("arst_q.out", sign_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset during debounce.
    @(negedge clk);
    enable = 1'b1; finger_in = 5'b01010;
    @(posedge clk); @(posedge clk);
    #2;
    chk("arst_s.busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_s.busy", busy, 0);
    chk("arst_s.fo", finger_out, 0);
    chk("arst_s.valid", sign_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    add(5'b10100, 12, 1);
    run_seq("resume");

    begin
      int len;
      logic [4:0] p;
      logic [4:0] pool [5];
      pool[0] = 5'b00010; pool[1] = 5'b10101; pool[2] = 5'b11111;
      pool[3] = 5'b01100; pool[4] = 5'b00000;
      while (xs.size() < 320) begin
        p   = pool[$urandom_range(0, 4)];
        len = $urandom_range(1, 11);
        repeat (len) begin
          xs.push_back(p);
          rdy.push_back(($urandom_range(0, 2) != 0));
        end
      end
    end
    run_seq("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sign_capture_controller.md
# sign_capture_controller

Sequences the SignIdentification datapath. It debounces the raw five-finger status from the sensor front end and applies only stable finger patterns to SignIdentification. It captures the registered `sign_value` one cycle later and queues each recognised sign in a small FIFO with a valid/ready output. It also prevents a held gesture from being reported more than once.

## Interface
- `STABLE_CYCLES`, 4: number of consecutive matching samples after the first sample before a pattern is applied; legal range 1–255.
- `FIFO_DEPTH`, 4: number of sign entries queued; must be a power of two, minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run/stop control for capture.
- `finger_in`  in  5  raw finger status, ordered {pinky, ring, middle, index, thumb}.
- `finger_out`  out  5  registered pattern, same order; drives the SignIdentification status inputs.
- `sign_value`  in  4  registered sign from SignIdentification; valid one clock after `finger_out` changes.
- `sign_out`  out  4  FIFO head entry.
- `sign_valid`  out  1  FIFO not empty.
- `sign_ready`  in  1  consumer accept; a pop happens when `sign_valid & sign_ready`.
- `overflow`  out  1  sticky flag; set when a capture is dropped because the FIFO is full.
- `busy`  out  1  high in SETTLE, APPLY or CAPTURE.

## Operation
- Reset values: state IDLE, `finger_out`=0, `sign_out`=0, `sign_valid`=0, `overflow`=0, `busy`=0, FIFO empty, candidate register and counter 0.
- **IDLE:**
  - With `enable`=1: candidate ← `finger_in`, count ← 0, go to SETTLE.
  - Otherwise stay in IDLE.
- **SETTLE:**
  - If `finger_in` ≠ candidate: candidate ← `finger_in`, count ← 0.
  - Else if count = `STABLE_CYCLES`−1: `finger_out` ← candidate, go to APPLY.
  - Else count increments.
- **APPLY:** wait one cycle for SignIdentification to register its output, then go to CAPTURE.
- **CAPTURE:**
  - Push `sign_value` into the FIFO.
  - If the FIFO is full with no pop in the same cycle, drop the entry and set `overflow`.
  - Go to HOLD.
- **HOLD:**
  - Stay while `finger_in` = `finger_out`.
  - On any difference: candidate ← `finger_in`, count ← 0, go to SETTLE.
- **Enable behaviour:**
  - `enable`=0 forces the next state to IDLE from every state.
  - A push already scheduled in CAPTURE still completes that cycle.
  - `finger_out` and the FIFO contents are retained.
- **FIFO:**
  - `sign_out` is the head entry; it shows 0 when the FIFO is empty.
  - A pop and a push in the same cycle are both honoured, including when the FIFO is full; no overflow is flagged in that case.
  - Occupancy counter width is log2(`FIFO_DEPTH`)+1; read and write pointers wrap modulo `FIFO_DEPTH`.
- **`overflow`:** cleared only by `rst`.

## Timing
- The first sampling edge of a new stable pattern V is e0, where V is loaded into the candidate register.
- `finger_out` = V after edge e(`STABLE_CYCLES`).
- SignIdentification registers its result at e(`STABLE_CYCLES`+1).
- The push happens at e(`STABLE_CYCLES`+2); `sign_valid` is high after that edge. With defaults this is 6 clocks from e0.
- Any glitch during SETTLE restarts the full debounce window from the glitch edge.
- A pattern returning to its previous value before HOLD is left causes no re-capture.
- An asynchronous `rst` mid-operation returns all outputs to their reset values immediately and empties the FIFO.
- `busy` is registered and decoded from the state.

## Test plan
- Reset then `enable`=1, `finger_in`=5'b00010 held → `finger_out`=5'b00010 after 4 edges; `sign_valid` rises 6 clocks after the first sample; `sign_out` equals the SignIdentification code for that pattern.
- During SETTLE, glitch 00110 → 00111 for one cycle → 00110 → capture time restarts from the glitch; exactly one push, of the final 00110 sign.
- Hold 11111 for 50 cycles → exactly one FIFO entry; change to 00010 → a second entry after 6 more clocks.
- `sign_ready`=0 with 5 distinct stable patterns → 4 entries queued and `overflow`=1; then `sign_ready`=1 → the 4 entries pop in order and `overflow` stays 1.
- FIFO full while `sign_ready`=1 in the CAPTURE cycle → head pops, new entry pushes, occupancy stays 4, `overflow` stays 0.
- Assert `rst` during SETTLE or with entries queued → `sign_valid`=0, `finger_out`=0, `busy`=0 immediately; after release with `enable`=1, normal capture resumes.
